uart_rx: RTL and testbench
==========================

# uart_rx

Serial receiver that sits directly downstream of the UART transmit stage and consumes its serial line. Frame format: idle-high line, start bit (0), 8 data bits MSB first, even parity bit, stop bit (1). The block synchronises the line, finds the start edge and samples each bit at mid-bit. It presents the recovered byte with a one-cycle valid strobe and parity/framing error flags.

## Interface
- `CLKS_PER_BIT`, 16: clock cycles per serial bit; legal range 4..255.
- `clk` input 1: single clock; all logic is on its rising edge.
- `rst` input 1: reset, synchronous and active-low.
- `rx_in` input 1: serial line, asynchronous to `clk`, idle high.
- `rx_data` output 8: last received byte; holds until the next frame completes.
- `rx_valid` output 1: one-cycle pulse when a frame completes.
- `parity_err` output 1: valid with `rx_valid`; received parity does not equal the XOR of the data bits.
- `frame_err` output 1: valid with `rx_valid`; stop bit was sampled low.
- `busy` output 1: high in every state other than IDLE.

## Operation
- `rx_in` passes through a 2-flop synchroniser; the result is `rx_s`. A third flop `rx_d` holds the previous `rx_s` for edge detection.
- The bit-phase counter `cnt` is 8 bits wide; `half = CLKS_PER_BIT/2`, rounded down. `bit_idx` is 3 bits.
- **IDLE**: a falling edge (`rx_d`=1, `rx_s`=0) loads `cnt`=0 and moves to START. A line held low never starts a frame, so a break condition produces no frames.
- **START**: when `cnt`==`half`-1:
  - `rx_s`=0: clear `cnt` and `bit_idx`, go to DATA.
  - `rx_s`=1: false start (glitch); go to IDLE with no output.
- **DATA**: when `cnt`==`CLKS_PER_BIT`-1:
  - shift `rx_s` into the shift register LSB side (MSB is received first);
  - clear `cnt`; after bit_idx 7, go to PARITY (or STOP if parity is compiled out).
- **PARITY**: at the mid-bit sample, capture `rx_s` into `par_bit`, then go to STOP.
- **STOP**: at the mid-bit sample:
  - load `rx_data` from the shift register;
  - `parity_err` = `par_bit` XOR (XOR-reduction of the shift register);
  - `frame_err` = ~`rx_s`;
  - pulse `rx_valid`, then go to IDLE.
- A frame with errors still updates `rx_data` and still pulses `rx_valid`.
- `parity_err` and `frame_err` are registered with `rx_valid` and hold their value until the next completed frame.
- Reset values (`rst`=0 at a clock edge):
  - state IDLE, `cnt`=0, `bit_idx`=0;
  - `rx_data`=8'h00, `rx_valid`=0, `parity_err`=0, `frame_err`=0, `busy`=0;
  - synchroniser flops and `rx_d` = 1.
- Reset mid-frame abandons the frame with no `rx_valid`. After release, the block needs a new falling edge to start.

## Timing
- Synchroniser latency is 2 clk. The start edge is recognised 3 clk after the line transition.
- Bit n (n=0 start … 10 stop) is sampled at `half`+n·`CLKS_PER_BIT` cycles after the edge is recognised.
- `rx_valid` rises on the clk edge after the stop-bit sample. It is high for exactly 1 cycle.
- At the clock edge where `rx_valid` rises, the state is already IDLE. A start edge arriving in that cycle is accepted, so back-to-back frames need no idle gap.
- The receiver tolerates ±(`half`-1)/(11·`CLKS_PER_BIT`) baud mismatch; it does not resynchronise on data edges.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - 11-bit frame; PARITY state present;
  - `parity_err` is computed as above.
- `UART_RX_PARITY_EN` undefined:
  - 10-bit frame (start, 8 data, stop); PARITY state and `par_bit` are removed;
  - DATA goes directly to STOP;
  - `parity_err` is tied to 0.

## Test plan
- Good frame: `CLKS_PER_BIT`=16, parity enabled, send 0xA5 with parity 0 and stop 1 -> one `rx_valid` pulse, `rx_data`=0xA5, `parity_err`=0, `frame_err`=0. Pulse occurs 3+8+10·16 clk after the start edge on `rx_in`.
- Parity error: send 0x3C with parity 1 -> `rx_data`=0x3C, `parity_err`=1, `frame_err`=0.
- Framing error and break: send 0x81 with stop bit 0, then hold the line low for 40 bit times -> `frame_err`=1 on the first frame only; no further `rx_valid` until the line goes high and then falls again.
- Glitch: drive `rx_in` low for 4 clk, then high -> START aborts at the mid-sample; no `rx_valid`; `busy` returns to 0.
- Back-to-back: send frames 0x00 then 0xFF with no idle gap -> two `rx_valid` pulses, `rx_data`=0x00 then 0xFF, no errors.
- Reset mid-frame: assert `rst`=0 during data bit 4 of a 0x55 frame -> all outputs return to reset values; no `rx_valid`. After release, a following 0x12 frame is received correctly.

Source files
------------

// File: rtl/uart_rx_if.sv
// uart_rx_if: serial line and received-byte bundle for the UART receiver.
//   rx_in      - serial line into the receiver, idle high
//   rx_data    - last received byte
//   rx_valid   - one-cycle strobe when a frame completes
//   parity_err - parity mismatch flag, valid with rx_valid
//   frame_err  - stop bit sampled low, valid with rx_valid
//   busy       - receiver is inside a frame
// Modports: slave = the receiver, master = whatever drives the line and consumes the byte.
interface uart_rx_if;
    logic       rx_in;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       parity_err;
    logic       frame_err;
    logic       busy;

    modport master (
        output rx_in,
        input  rx_data,
        input  rx_valid,
        input  parity_err,
        input  frame_err,
        input  busy
    );

    modport slave (
        input  rx_in,
        output rx_data,
        output rx_valid,
        output parity_err,
        output frame_err,
        output busy
    );
endinterface

// File: rtl/uart_rx.sv
// uart_rx: UART receiver, idle-high line, start bit, 8 data bits MSB first,
// optional even parity bit, stop bit. Each bit is sampled at mid-bit; no
// resynchronisation on data edges.
//   clk  - single clock, rising edge
//   rst  - synchronous, active-low reset
//   bus  - uart_rx_if.slave: rx_in in; rx_data, rx_valid, parity_err, frame_err, busy out
// Build option: define UART_RX_PARITY_EN to receive an 11-bit frame with an even
// parity bit; without it the frame is 10 bits and parity_err is tied low.
module uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic     clk,
    input  logic     rst,
    uart_rx_if.slave bus
);

    localparam logic [7:0] HALF_M1 = 8'(CLKS_PER_BIT / 2 - 1);
    localparam logic [7:0] LAST    = 8'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
`ifdef UART_RX_PARITY_EN
        StParity,
`endif
        StStop
    } state_e;

    state_e     state_q;
    logic [7:0] cnt_q;
    logic [2:0] bit_idx_q;
    logic [7:0] shift_q;
    logic       rx_meta_q;
    logic       rx_s_q;
    logic       rx_d_q;
    logic [7:0] rx_data_q;
    logic       rx_valid_q;
    logic       frame_err_q;
`ifdef UART_RX_PARITY_EN
    logic       par_bit_q;
    logic       parity_err_q;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            rx_meta_q   <= 1'b1;
            rx_s_q      <= 1'b1;
            rx_d_q      <= 1'b1;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit_q    <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            rx_meta_q  <= bus.rx_in;
            rx_s_q     <= rx_meta_q;
            rx_d_q     <= rx_s_q;
            rx_valid_q <= 1'b0;
            cnt_q      <= cnt_q + 8'd1;

            case (state_q)
                StIdle: begin
                    cnt_q <= '0;
                    // Only a real high-to-low transition starts a frame, so a
                    // line stuck low (break) never produces frames.
                    if (rx_d_q && !rx_s_q) begin
                        state_q <= StStart;
                    end
                end
                StStart: begin
                    if (cnt_q == HALF_M1) begin
                        cnt_q     <= '0;
                        bit_idx_q <= '0;
                        // Line back high at mid start bit: treat as a glitch.
                        state_q   <= rx_s_q ? StIdle : StData;
                    end
                end
                StData: begin
                    if (cnt_q == LAST) begin
                        shift_q   <= {shift_q[6:0], rx_s_q};
                        cnt_q     <= '0;
                        bit_idx_q <= bit_idx_q + 3'd1;
                        if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state_q <= StParity;
`else
                            state_q <= StStop;
`endif
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                StParity: begin
                    if (cnt_q == LAST) begin
                        par_bit_q <= rx_s_q;
                        cnt_q     <= '0;
                        state_q   <= StStop;
                    end
                end
`endif
                StStop: begin
                    if (cnt_q == LAST) begin
                        // Errored frames are still delivered; the flags qualify them.
                        rx_data_q    <= shift_q;
                        frame_err_q  <= ~rx_s_q;
`ifdef UART_RX_PARITY_EN
                        parity_err_q <= par_bit_q ^ (^shift_q);
`endif
                        rx_valid_q   <= 1'b1;
                        cnt_q        <= '0;
                        state_q      <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.rx_data   = rx_data_q;
    assign bus.rx_valid  = rx_valid_q;
    assign bus.frame_err = frame_err_q;
    assign bus.busy      = (state_q != StIdle);
`ifdef UART_RX_PARITY_EN
    assign bus.parity_err = parity_err_q;
`else
    assign bus.parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed bench for uart_rx at CLKS_PER_BIT = 16. Builds with or
// without UART_RX_PARITY_EN; the parity bit is only put on the line when enabled.
module tb_uart_rx;

    localparam int unsigned CPB = 16;
`ifdef UART_RX_PARITY_EN
    localparam bit          PAR_EN  = 1'b1;
    // 3 clk sync + edge detect, 8 clk to mid start bit, 10 bits to mid stop bit
    localparam int unsigned EXP_LAT = 3 + 8 + 10 * 16;
`else
    localparam bit          PAR_EN  = 1'b0;
    localparam int unsigned EXP_LAT = 3 + 8 + 9 * 16;
`endif

    logic clk;
    logic rst;
    uart_rx_if bus ();

    uart_rx #(
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned cyc      = 0;
    int unsigned edge_cyc = 0;
    int unsigned pulses   = 0;
    int unsigned last_lat = 0;
    logic [7:0]  cap_data [0:15];
    logic        cap_perr [0:15];
    logic        cap_ferr [0:15];

    always @(posedge clk) cyc <= cyc + 1;

    // Capture every rx_valid cycle; a stretched pulse shows up as extra pulses.
    always @(negedge clk) begin
        if (bus.rx_valid === 1'b1) begin
            cap_data[pulses % 16] = bus.rx_data;
            cap_perr[pulses % 16] = bus.parity_err;
            cap_ferr[pulses % 16] = bus.frame_err;
            last_lat = cyc - edge_cyc;
            pulses++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic b);
        bus.rx_in = b;
        repeat (CPB) tick();
    endtask

    task automatic idle_bits(input int unsigned n);
        bus.rx_in = 1'b1;
        repeat (n * CPB) tick();
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
        edge_cyc = cyc;
        drive_bit(1'b0);
        for (int i = 7; i >= 0; i--) drive_bit(d[i]);
        if (PAR_EN) drive_bit(par);
        drive_bit(stop);
    endtask

    int unsigned p0;

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        bus.rx_in = 1'b1;
        rst = 1'b0;
        repeat (4) tick();
        check("rst_data",  32'(bus.rx_data),    32'h00);
        check("rst_valid", 32'(bus.rx_valid),   32'h0);
        check("rst_perr",  32'(bus.parity_err), 32'h0);
        check("rst_ferr",  32'(bus.frame_err),  32'h0);
        check("rst_busy",  32'(bus.busy),       32'h0);
        rst = 1'b1;
        idle_bits(2);

        // Good frame 0xA5 (four ones, even parity 0)
        p0 = pulses;
        send_frame(8'hA5, 1'b0, 1'b1);
        idle_bits(1);
        check("good_pulses", pulses - p0,            32'd1);
        check("good_data",   32'(cap_data[p0 % 16]), 32'hA5);
        check("good_perr",   32'(cap_perr[p0 % 16]), 32'h0);
        check("good_ferr",   32'(cap_ferr[p0 % 16]), 32'h0);
        check("good_lat",    last_lat,               EXP_LAT);
        check("good_hold",   32'(bus.rx_data),       32'hA5);
        check("good_vlow",   32'(bus.rx_valid),      32'h0);

        // 0x3C with odd parity bit
        p0 = pulses;
        send_frame(8'h3C, 1'b1, 1'b1);
        idle_bits(1);
        check("par_pulses", pulses - p0,            32'd1);
        check("par_data",   32'(cap_data[p0 % 16]), 32'h3C);
        check("par_perr",   32'(cap_perr[p0 % 16]), 32'(PAR_EN));
        check("par_ferr",   32'(cap_ferr[p0 % 16]), 32'h0);
        check("par_hold",   32'(bus.parity_err),    32'(PAR_EN));

        // Reset during data bit 4 of 0x55 (bits 7..4 = 0,1,0,1)
        p0 = pulses;
        drive_bit(1'b0);
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        bus.rx_in = 1'b1;
        repeat (CPB / 2) tick();
        check("mid_busy", 32'(bus.busy), 32'h1);
        rst = 1'b0;
        repeat (2) tick();
        check("mrst_data",  32'(bus.rx_data),    32'h00);
        check("mrst_valid", 32'(bus.rx_valid),   32'h0);
        check("mrst_perr",  32'(bus.parity_err), 32'h0);
        check("mrst_ferr",  32'(bus.frame_err),  32'h0);
        check("mrst_busy",  32'(bus.busy),       32'h0);
        rst = 1'b1;
        idle_bits(12);
        check("mrst_nopulse", pulses - p0, 32'd0);
        send_frame(8'h12, 1'b0, 1'b1);
        idle_bits(1);
        check("post_pulses", pulses - p0,            32'd1);
        check("post_data",   32'(cap_data[p0 % 16]), 32'h12);
        check("post_perr",   32'(cap_perr[p0 % 16]), 32'h0);
        check("post_ferr",   32'(cap_ferr[p0 % 16]), 32'h0);

        // Glitch: low for 4 clk only
        p0 = pulses;
        bus.rx_in = 1'b0;
        repeat (4) tick();
        check("gl_busy", 32'(bus.busy), 32'h1);
        bus.rx_in = 1'b1;
        repeat (20) tick();
        check("gl_idle",    32'(bus.busy), 32'h0);
        check("gl_nopulse", pulses - p0,   32'd0);
        idle_bits(1);

        // 0x81 with stop bit low, then 40 bit times of break
        p0 = pulses;
        send_frame(8'h81, 1'b0, 1'b0);
        bus.rx_in = 1'b0;
        repeat (40 * CPB) tick();
        check("fe_pulses", pulses - p0,            32'd1);
        check("fe_data",   32'(cap_data[p0 % 16]), 32'h81);
        check("fe_ferr",   32'(cap_ferr[p0 % 16]), 32'h1);
        check("fe_perr",   32'(cap_perr[p0 % 16]), 32'h0);
        check("brk_busy",  32'(bus.busy),          32'h0);
        idle_bits(2);
        check("brk_nopulse", pulses - p0, 32'd1);
        send_frame(8'h5A, 1'b0, 1'b1);
        idle_bits(1);
        check("rec_pulses", pulses - p0,                  32'd2);
        check("rec_data",   32'(cap_data[(p0 + 1) % 16]), 32'h5A);
        check("rec_ferr",   32'(cap_ferr[(p0 + 1) % 16]), 32'h0);

        // Back-to-back 0x00 then 0xFF, no idle gap
        p0 = pulses;
        send_frame(8'h00, 1'b0, 1'b1);
        send_frame(8'hFF, 1'b0, 1'b1);
        idle_bits(1);
        check("b2b_pulses", pulses - p0,                  32'd2);
        check("b2b_data0",  32'(cap_data[p0 % 16]),       32'h00);
        check("b2b_data1",  32'(cap_data[(p0 + 1) % 16]), 32'hFF);
        check("b2b_perr0",  32'(cap_perr[p0 % 16]),       32'h0);
        check("b2b_perr1",  32'(cap_perr[(p0 + 1) % 16]), 32'h0);
        check("b2b_ferr0",  32'(cap_ferr[p0 % 16]),       32'h0);
        check("b2b_ferr1",  32'(cap_ferr[(p0 + 1) % 16]), 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
